// File: rtl/fetch_pc_npc_unit.sv
// fetch_pc_npc_unit: SPARC-style fetch stage holding the PC/nPC pair.
// It applies delayed-branch redirects from decode and holds state under stall.
// It flags annulled delay-slot instructions to IF/ID and counts advancing fetches.
// Optional feature macro: FETCH_ALIGN_CHECK_EN. When defined, a redirect to a
// misaligned target raises a sticky misalign_trap and parks the unit in HALT.
// When undefined, the low two target bits are forced to 00.
module fetch_pc_npc_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        LE,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  input  logic        annul,
  output logic [31:0] PC,
  output logic [31:0] nPC,
  output logic        fetch_valid,
  output logic        if_id_squash,
  output logic [31:0] instr_count,
  output logic        misalign_trap
);

`ifdef FETCH_ALIGN_CHECK_EN
  typedef enum logic [1:0] {BOOT, RUN, STALL, HALT} state_t;
`else
  typedef enum logic [1:0] {BOOT, RUN, STALL} state_t;
`endif

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] npc_q, npc_d;
  logic        fetch_valid_q, fetch_valid_d;
  logic        if_id_squash_q, if_id_squash_d;
  logic [31:0] instr_count_q, instr_count_d;
  logic        pending_redir_q, pending_redir_d;
  logic        pending_annul_q, pending_annul_d;
  logic [31:0] pending_target_q, pending_target_d;

  logic        redir_use;
  logic [31:0] target_raw;
  logic [31:0] target_aligned;
  logic [31:0] npc_plus4;
  logic        target_misaligned;

  // Select the redirect source: a live branch beats one parked during a stall.
  always_comb begin
    redir_use      = branch_taken | pending_redir_q;
    target_raw     = branch_taken ? branch_target : pending_target_q;
    target_aligned = target_raw & ~32'h0000_0003;
    npc_plus4      = npc_q + 32'd4;
`ifdef FETCH_ALIGN_CHECK_EN
    target_misaligned = redir_use & (target_raw[1:0] != 2'b00);
`else
    target_misaligned = 1'b0;
`endif
  end

`ifdef FETCH_ALIGN_CHECK_EN
  logic misalign_trap_q, misalign_trap_d;
`endif

  // Next-state logic for the fetch FSM and every registered output.
  always_comb begin
    state_d          = state_q;
    pc_d             = pc_q;
    npc_d            = npc_q;
    fetch_valid_d    = fetch_valid_q;
    if_id_squash_d   = 1'b0;
    instr_count_d    = instr_count_q;
    pending_redir_d  = pending_redir_q;
    pending_annul_d  = pending_annul_q;
    pending_target_d = pending_target_q;
`ifdef FETCH_ALIGN_CHECK_EN
    misalign_trap_d  = misalign_trap_q;
`endif
    case (state_q)
      BOOT: begin
        state_d       = RUN;
        fetch_valid_d = 1'b1;
      end
      RUN, STALL: begin
        if (LE) begin
          pending_redir_d = 1'b0;
          pending_annul_d = 1'b0;
          if (target_misaligned) begin
`ifdef FETCH_ALIGN_CHECK_EN
            state_d         = HALT;
            fetch_valid_d   = 1'b0;
            misalign_trap_d = 1'b1;
`endif
          end else begin
            state_d        = RUN;
            pc_d           = npc_q;
            npc_d          = redir_use ? target_aligned : npc_plus4;
            instr_count_d  = instr_count_q + 32'd1;
            if_id_squash_d = annul | pending_annul_q;
          end
        end else begin
          state_d = STALL;
          if (branch_taken) begin
            pending_redir_d  = 1'b1;
            pending_target_d = branch_target;
          end
          if (annul) begin
            pending_annul_d = 1'b1;
          end
        end
      end
`ifdef FETCH_ALIGN_CHECK_EN
      HALT: begin
        fetch_valid_d = 1'b0;
      end
`endif
      default: begin
        state_d       = BOOT;
        fetch_valid_d = 1'b0;
      end
    endcase
  end

  // State register with synchronous reset overriding every other input.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q          <= BOOT;
      pc_q             <= RESET_PC;
      npc_q            <= RESET_PC + 32'd4;
      fetch_valid_q    <= 1'b0;
      if_id_squash_q   <= 1'b0;
      instr_count_q    <= 32'd0;
      pending_redir_q  <= 1'b0;
      pending_annul_q  <= 1'b0;
      pending_target_q <= 32'd0;
    end else begin
      state_q          <= state_d;
      pc_q             <= pc_d;
      npc_q            <= npc_d;
      fetch_valid_q    <= fetch_valid_d;
      if_id_squash_q   <= if_id_squash_d;
      instr_count_q    <= instr_count_d;
      pending_redir_q  <= pending_redir_d;
      pending_annul_q  <= pending_annul_d;
      pending_target_q <= pending_target_d;
    end
  end

`ifdef FETCH_ALIGN_CHECK_EN
  // Sticky trap flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      misalign_trap_q <= 1'b0;
    end else begin
      misalign_trap_q <= misalign_trap_d;
    end
  end

  assign misalign_trap = misalign_trap_q;
`else
  assign misalign_trap = 1'b0;
`endif

  assign PC           = pc_q;
  assign nPC          = npc_q;
  assign fetch_valid  = fetch_valid_q;
  assign if_id_squash = if_id_squash_q;
  assign instr_count  = instr_count_q;

endmodule

// File: tb/tb_fetch_pc_npc_unit.sv
// tb_fetch_pc_npc_unit: scoreboard bench for fetch_pc_npc_unit.
// Expected register values are pushed when stimulus is driven and popped
// one cycle later. A second instance checks PC wrap from a high RESET_PC.
module tb_fetch_pc_npc_unit;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] npc;
    logic        valid;
    logic        squash;
    logic [31:0] count;
    logic        trap;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        le = 1'b1;
  logic        branchTaken = 1'b0;
  logic [31:0] branchTarget = 32'd0;
  logic        annul = 1'b0;
  logic [31:0] pc, npc, instrCount;
  logic        fetchValid, squash, trap;

  logic        wrapReset = 1'b1;
  logic [31:0] wPc, wNpc, wCount;
  logic        wValid, wSquash, wTrap;

  exp_t expQ[$];
  int   compareCount = 0;
  int   failCount = 0;
  int   stepNo = 0;

  always #5 clk = ~clk;

  fetch_pc_npc_unit #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .LE(le), .branch_taken(branchTaken),
    .branch_target(branchTarget), .annul(annul), .PC(pc), .nPC(npc),
    .fetch_valid(fetchValid), .if_id_squash(squash),
    .instr_count(instrCount), .misalign_trap(trap)
  );

  fetch_pc_npc_unit #(.RESET_PC(32'hFFFF_FFF8)) dutWrap (
    .clk(clk), .reset(wrapReset), .LE(1'b1), .branch_taken(1'b0),
    .branch_target(32'd0), .annul(1'b0), .PC(wPc), .nPC(wNpc),
    .fetch_valid(wValid), .if_id_squash(wSquash),
    .instr_count(wCount), .misalign_trap(wTrap)
  );

  // Count one comparison and report it if the observed value is wrong.
  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    compareCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s got=%h expected=%h", tag, got, exp);
    end
  endtask

  // Drive one cycle of inputs and queue the values expected after the edge.
  task automatic applyStimulus(input logic rst, input logic l, input logic bt,
                               input logic [31:0] tgt, input logic an,
                               input logic [31:0] ePc, input logic [31:0] eNpc,
                               input logic eValid, input logic eSquash,
                               input logic [31:0] eCount, input logic eTrap);
    exp_t e;
    reset = rst;
    le = l;
    branchTaken = bt;
    branchTarget = tgt;
    annul = an;
    e.pc = ePc;
    e.npc = eNpc;
    e.valid = eValid;
    e.squash = eSquash;
    e.count = eCount;
    e.trap = eTrap;
    expQ.push_back(e);
    @(posedge clk);
    #1;
    popAndCompare();
  endtask

  // Pop the oldest expectation and compare it with the DUT outputs.
  task automatic popAndCompare();
    exp_t e;
    stepNo++;
    if (expQ.size() == 0) begin
      checkOutput($sformatf("s%0d.queue_empty", stepNo), 32'd1, 32'd0);
    end else begin
      e = expQ.pop_front();
      checkOutput($sformatf("s%0d.pc", stepNo), pc, e.pc);
      checkOutput($sformatf("s%0d.npc", stepNo), npc, e.npc);
      checkOutput($sformatf("s%0d.valid", stepNo), {31'd0, fetchValid}, {31'd0, e.valid});
      checkOutput($sformatf("s%0d.squash", stepNo), {31'd0, squash}, {31'd0, e.squash});
      checkOutput($sformatf("s%0d.count", stepNo), instrCount, e.count);
      checkOutput($sformatf("s%0d.trap", stepNo), {31'd0, trap}, {31'd0, e.trap});
    end
  endtask

  // Absolute time bound so the run always terminates.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [31:0] wrapPc[5];
    logic [31:0] wrapNpc[5];
    wrapPc  = '{32'hFFFF_FFF8, 32'hFFFF_FFF8, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004};
    wrapNpc = '{32'hFFFF_FFFC, 32'hFFFF_FFFC, 32'h0000_0000, 32'h0000_0004, 32'h0000_0008};

    // Reset, boot, then straight-line fetch 0,4,8,C.
    applyStimulus(1, 1, 0, 0, 0, 32'h0, 32'h4, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 32'h4, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h4, 32'h8, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h8, 32'hC, 1, 0, 2, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'hC, 32'h10, 1, 0, 3, 0);

    // Re-reset and reach PC=8, then redirect to 0x100.
    applyStimulus(1, 1, 0, 0, 0, 32'h0, 32'h4, 0, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h0, 32'h4, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h4, 32'h8, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h8, 32'hC, 1, 0, 2, 0);
    applyStimulus(0, 1, 1, 32'h100, 0, 32'hC, 32'h100, 1, 0, 3, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h100, 32'h104, 1, 0, 4, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h104, 32'h108, 1, 0, 5, 0);

    // Redirect with annul: squash for exactly one cycle.
    applyStimulus(0, 1, 1, 32'h200, 1, 32'h108, 32'h200, 1, 1, 6, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h200, 32'h204, 1, 0, 7, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h204, 32'h208, 1, 0, 8, 0);

    // Three-cycle stall with a single branch pulse, then release.
    applyStimulus(0, 0, 1, 32'h40, 0, 32'h204, 32'h208, 1, 0, 8, 0);
    applyStimulus(0, 0, 0, 0, 0, 32'h204, 32'h208, 1, 0, 8, 0);
    applyStimulus(0, 0, 0, 0, 0, 32'h204, 32'h208, 1, 0, 8, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h208, 32'h40, 1, 0, 9, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h40, 32'h44, 1, 0, 10, 0);

    // Pending annul plus live branch at release: live target wins.
    applyStimulus(0, 0, 1, 32'h80, 1, 32'h40, 32'h44, 1, 0, 10, 0);
    applyStimulus(0, 0, 1, 32'h90, 0, 32'h40, 32'h44, 1, 0, 10, 0);
    applyStimulus(0, 1, 1, 32'hA0, 0, 32'h44, 32'hA0, 1, 1, 11, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'hA0, 32'hA4, 1, 0, 12, 0);

    // Two branches during a stall: newest pending target wins.
    applyStimulus(0, 0, 1, 32'h80, 0, 32'hA0, 32'hA4, 1, 0, 12, 0);
    applyStimulus(0, 0, 1, 32'h90, 0, 32'hA0, 32'hA4, 1, 0, 12, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'hA4, 32'h90, 1, 0, 13, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h90, 32'h94, 1, 0, 14, 0);

    // Misaligned redirect target 0x102.
`ifdef FETCH_ALIGN_CHECK_EN
    applyStimulus(0, 1, 1, 32'h102, 0, 32'h90, 32'h94, 0, 0, 14, 1);
    applyStimulus(0, 1, 0, 0, 1, 32'h90, 32'h94, 0, 0, 14, 1);
    applyStimulus(0, 0, 1, 32'h300, 0, 32'h90, 32'h94, 0, 0, 14, 1);
`else
    applyStimulus(0, 1, 1, 32'h102, 0, 32'h94, 32'h100, 1, 0, 15, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h100, 32'h104, 1, 0, 16, 0);
    applyStimulus(0, 0, 1, 32'h300, 0, 32'h100, 32'h104, 1, 0, 16, 0);
`endif

    // Reset mid-stall with a live redirect; pending state must be cleared.
    applyStimulus(1, 0, 1, 32'h300, 1, 32'h0, 32'h4, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 32'h0, 32'h4, 1, 0, 0, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h4, 32'h8, 1, 0, 1, 0);
    applyStimulus(0, 1, 0, 0, 0, 32'h8, 32'hC, 1, 0, 2, 0);

    // Wrap-around instance: PC FFFF_FFF8, FFFF_FFFC, 0, 4.
    @(posedge clk);
    #1;
    wrapReset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      checkOutput($sformatf("wrap%0d.pc", i), wPc, wrapPc[i]);
      checkOutput($sformatf("wrap%0d.npc", i), wNpc, wrapNpc[i]);
      @(posedge clk);
      #1;
    end
    checkOutput("wrap.count", wCount, 32'd4);
    checkOutput("wrap.valid", {31'd0, wValid}, 32'd1);
    checkOutput("wrap.squash_trap", {30'd0, wSquash, wTrap}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
